// File: rtl/cmos_line_stitch_pkg.sv
// Shared types and helpers for the multi-camera line stitcher.
package cmos_pkg;

    localparam int unsigned PIX565_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    // Bit width able to index v values; never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/cmos_line_stitch_fifo.sv
// Single-clock line FIFO with registered read data and synchronous flush.
module cmos_line_fifo
    import cmos_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = clog2_min1(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr_q, rptr_q;
    logic              push_c, pop_c;

    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty  = (wptr_q == rptr_q);
    assign push_c = wr_en && !full && !clr;
    assign pop_c  = rd_en && !empty && !clr;

    always_ff @(posedge clk) begin
        if (push_c) mem[wptr_q[AW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            dout   <= '0;
        end else if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_c) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop_c) begin
                rptr_q <= rptr_q + (AW+1)'(1);
                dout   <= mem[rptr_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/cmos_line_stitch.sv
// Side-by-side stitcher: buffers one line per camera, then emits ch0..chN-1 as one line.
module cmos_line_stitch
    import cmos_pkg::*;
#(
    parameter int unsigned      DATA_W     = PIX565_W,
    parameter int unsigned      NUM_CH     = 2,
    parameter int unsigned      LINE_W     = 640,
    parameter int unsigned      FIFO_DEPTH = 1024,
    parameter int unsigned      FRAME_DIV  = 1,
    parameter int unsigned      HBLANK     = 16,
    parameter logic [DATA_W-1:0] PAD_VAL   = '0
) (
    input  logic                     cmos_pclk,
    input  logic                     sys_rst_n,
    input  logic [NUM_CH-1:0]        cmos_href,
    input  logic [NUM_CH-1:0]        cmos_vsync,
    input  logic [NUM_CH*DATA_W-1:0] cmos_data,
    output logic                     pixel_vsync,
    output logic                     pixel_href,
    output logic [DATA_W-1:0]        pixel_data,
    output logic [NUM_CH-1:0]        ovf_err,
    output logic [NUM_CH-1:0]        udf_err
);

    localparam int unsigned WC_W   = clog2_min1(LINE_W + 1);
    localparam int unsigned PIX_W  = clog2_min1(LINE_W);
    localparam int unsigned CH_W   = clog2_min1(NUM_CH);
    localparam int unsigned GAP_W  = clog2_min1(HBLANK);
    localparam int unsigned PEND_W = $clog2(FIFO_DEPTH / LINE_W) + 1;
    localparam int unsigned FC_W   = 4;

    state_e                  state_q, state_d;
    logic [NUM_CH-1:0]       vs_q, href_q, href_fall_c, wr_en_c, rd_vec_c;
    logic [NUM_CH-1:0]       fifo_full, fifo_empty, pend_nz_c;
    logic [DATA_W-1:0]       fifo_dout [NUM_CH];
    logic [WC_W-1:0]         wcnt_q [NUM_CH];
    logic [PEND_W-1:0]       pend_q [NUM_CH];
    logic [FC_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic [CH_W-1:0]         ch_q, sel_q;
    logic [PIX_W-1:0]        pix_q;
    logic [GAP_W-1:0]        gap_q;
    logic                    frame_start_c, keep_c, rd_en_c, pix_wrap_c, last_ch_c;
    logic                    vsync_q, out_href_q, pad_q;

    assign frame_start_c = cmos_vsync[0] & ~vs_q[0];
    assign keep_c        = (frame_cnt_q == '0);
    assign frame_cnt_d   = !frame_start_c ? frame_cnt_q :
                           (frame_cnt_q == FC_W'(FRAME_DIV - 1)) ? '0 : frame_cnt_q + FC_W'(1);
    assign href_fall_c   = href_q & ~cmos_href;

    // Per-channel write gating: only kept frames, only the first LINE_W pixels of a line.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            wr_en_c[k]   = cmos_href[k] && keep_c && (wcnt_q[k] < WC_W'(LINE_W)) && !frame_start_c;
            pend_nz_c[k] = (pend_q[k] != '0);
            rd_vec_c[k]  = rd_en_c && (ch_q == CH_W'(k));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        cmos_line_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (cmos_pclk),
            .rst_n (sys_rst_n),
            .clr   (frame_start_c),
            .wr_en (wr_en_c[g]),
            .din   (cmos_data[g*DATA_W +: DATA_W]),
            .rd_en (rd_vec_c[g]),
            .dout  (fifo_dout[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
        );
    end

    always_ff @(posedge cmos_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (&pend_nz_c) state_d = SEND;
            SEND:    if (pix_wrap_c && last_ch_c) state_d = GAP;
            GAP:     if (gap_q == GAP_W'(HBLANK - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (frame_start_c) state_d = IDLE;
    end

    always_comb begin
        rd_en_c    = (state_q == SEND) && !frame_start_c;
        pix_wrap_c = rd_en_c && (pix_q == PIX_W'(LINE_W - 1));
        last_ch_c  = (ch_q == CH_W'(NUM_CH - 1));
    end

    // Line counters, pending-line bookkeeping, sticky flags and output registers.
    always_ff @(posedge cmos_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vs_q        <= '0;
            href_q      <= '0;
            frame_cnt_q <= '0;
            ovf_err     <= '0;
            udf_err     <= '0;
            ch_q        <= '0;
            pix_q       <= '0;
            gap_q       <= '0;
            sel_q       <= '0;
            vsync_q     <= 1'b0;
            out_href_q  <= 1'b0;
            pad_q       <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                wcnt_q[k] <= '0;
                pend_q[k] <= '0;
            end
        end else begin
            vs_q        <= cmos_vsync;
            href_q      <= cmos_href;
            frame_cnt_q <= frame_cnt_d;
            vsync_q     <= (|cmos_vsync) && (frame_cnt_d == '0);
            out_href_q  <= rd_en_c;
            pad_q       <= rd_en_c && fifo_empty[ch_q];
            sel_q       <= ch_q;
            if (frame_start_c) begin
                ovf_err <= '0;
                udf_err <= '0;
                ch_q    <= '0;
                pix_q   <= '0;
                gap_q   <= '0;
                for (int k = 0; k < NUM_CH; k++) begin
                    wcnt_q[k] <= '0;
                    pend_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (href_fall_c[k])  wcnt_q[k] <= '0;
                    else if (wr_en_c[k]) wcnt_q[k] <= wcnt_q[k] + WC_W'(1);
                    if (href_fall_c[k] && (wcnt_q[k] != '0) && !(pix_wrap_c && ch_q == CH_W'(k))) begin
                        if (pend_q[k] != {PEND_W{1'b1}}) pend_q[k] <= pend_q[k] + PEND_W'(1);
                    end else if (!(href_fall_c[k] && (wcnt_q[k] != '0)) && pix_wrap_c && ch_q == CH_W'(k)) begin
                        if (pend_q[k] != '0) pend_q[k] <= pend_q[k] - PEND_W'(1);
                    end
                    if (wr_en_c[k] && fifo_full[k])   ovf_err[k] <= 1'b1;
                    if (rd_vec_c[k] && fifo_empty[k]) udf_err[k] <= 1'b1;
                end
                if (rd_en_c) pix_q <= pix_wrap_c ? '0 : pix_q + PIX_W'(1);
                if (pix_wrap_c) ch_q <= last_ch_c ? '0 : ch_q + CH_W'(1);
                gap_q <= (state_q == GAP) ? gap_q + GAP_W'(1) : '0;
            end
        end
    end

    assign pixel_vsync = vsync_q;
    assign pixel_href  = out_href_q;
    assign pixel_data  = !out_href_q ? '0 : pad_q ? PAD_VAL : fifo_dout[sel_q];

endmodule
